load_store_unit: RTL
====================

# load_store_unit

Multi-cycle data-memory access unit between the single-cycle core datapath and an external handshaked data bus. It takes the datapath's ALU result as the effective address, register rs2 data as store data, and the load/store `funct3`, and performs byte-lane alignment and load sign/zero extension. It issues a request/acknowledge bus transaction and returns formatted load data to the result multiplexer. While the transaction is outstanding it asserts `stall`, which freezes PC update and register-file write-back.

## Interface
- `TIMEOUT_CYCLES`, 16: cycles in REQ without `bus_ack` before the access is aborted with an error.
- `clk`  input  1  core clock; all state updates on rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `mem_read`  input  1  current instruction is a load.
- `mem_write`  input  1  current instruction is a store; has priority if both are high.
- `funct3`  input  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- `addr`  input  32  effective byte address (ALU result).
- `store_data`  input  32  store source (rs2).
- `read_data`  output  32  formatted load result to the result mux; valid in DONE.
- `stall`  output  1  core must hold PC and suppress register write this cycle.
- `fault`  output  1  one-cycle pulse: misaligned address or illegal `funct3`.
- `bus_err`  output  1  one-cycle pulse: bus timeout.
- `bus_req`  output  1  bus request, level.
- `bus_we`  output  1  1 = write.
- `bus_addr`  output  32  word-aligned address (`addr[31:2]`, 2'b00).
- `bus_be`  output  4  byte enables.
- `bus_wdata`  output  32  lane-replicated write data.
- `bus_ack`  input  1  completion; sampled only in REQ.
- `bus_rdata`  input  32  read word; valid with `bus_ack`.

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE with an access (`mem_read` or `mem_write`) and a legal, aligned access:
  - Latch `bus_we`, `bus_addr`, `bus_be`, `bus_wdata`, `funct3` and `addr[1:0]`.
  - Go to REQ.
  - `stall`=1 combinationally in this cycle.
- IDLE with an illegal access (`funct3` of 011/110/111, or a store with 1xx), a halfword at `addr[0]`=1, or a word at `addr[1:0]`≠0:
  - No bus access; stay in IDLE.
  - `fault`=1 and `stall`=0 this cycle; `read_data`=0.
  - The core treats the instruction as a no-op write.
- REQ:
  - `bus_req`=1 and `stall`=1; all bus outputs stay stable until acknowledged.
  - On `bus_ack`: capture `bus_rdata` and go to DONE.
  - A timeout counter increments each REQ cycle. When it reaches `TIMEOUT_CYCLES`, drop `bus_req`, pulse `bus_err`, force the captured data to 0 and go to DONE.
- DONE:
  - `stall`=0 and `read_data` is valid, so the core completes the instruction at this edge.
  - Unconditional return to IDLE. Enables seen in DONE are ignored, because they belong to the completing instruction.
- Byte enables and store data:
  - SB: `bus_be` = 1 << `addr[1:0]`; `bus_wdata` = byte replicated ×4.
  - SH: `bus_be` = 0011 if `addr[1]`=0, else 1100; `bus_wdata` = halfword replicated ×2.
  - SW: `bus_be` = 1111.
- Load formatting: select the lane using the latched `addr[1:0]`. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- `read_data` is 0 in any state other than DONE.

## Timing
- Reset: state IDLE; `bus_req`, `bus_we`, `stall`, `fault` and `bus_err` = 0; `bus_addr`, `bus_be`, `bus_wdata` and `read_data` = 0; timeout counter = 0.
- Minimum access (ack in the first REQ cycle) takes 3 cycles: IDLE(stall) → REQ(stall, ack) → DONE(no stall).
- Latency in general = 2 + (cycles in REQ before `bus_ack`) cycles.
- `bus_ack` outside REQ is ignored.
- An ack arriving in the same cycle the counter reaches `TIMEOUT_CYCLES` counts as success: no `bus_err`, and the data is captured.
- Counter is 0 on REQ entry. It needs width clog2(`TIMEOUT_CYCLES`+1) and must not wrap.
- Reset asserted mid-transaction: `bus_req` drops asynchronously and the FSM returns to IDLE; the pending ack is discarded.
- Non-memory instructions in IDLE: `stall`=0 and no bus activity.

## Structure
- Shared package: `funct3` encodings (LB..LHU), FSM state enum, and the `bus_be` patterns.
- One natural sub-module: `load_formatter`, a combinational lane select and sign/zero extension from (word, `addr[1:0]`, `funct3`).
- The FSM, the latches and the store lane replication live in the top.

## Test plan
- LW at 0x100, ack on the first REQ cycle, `bus_rdata`=0xDEADBEEF → `read_data`=0xDEADBEEF in DONE; `stall` high for exactly 2 cycles.
- LB at 0x103 with `bus_rdata`=0x80FF0000 → `read_data`=0xFFFFFF80. LBU at 0x103 → 0x00000080. LHU at 0x102 → 0x000080FF.
- SB of 0x000000AB at 0x201 → `bus_be`=0010, `bus_wdata`=0xABABABAB, `bus_addr`=0x200, `bus_we`=1. SH at 0x202 → `bus_be`=1100.
- LW at 0x102, or `funct3`=011 → `fault` pulse, `bus_req` never asserts, `stall`=0.
- No ack for 16 cycles → `bus_err` pulse, then DONE with `read_data`=0. Ack on cycle 16 → success with no `bus_err`.
- Reset asserted in cycle 2 of REQ → `bus_req`=0 immediately; a later ack is ignored; a following LW completes normally.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: funct3 access codes, FSM states, byte-enable patterns.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a.
package load_store_unit_pkg;

    // Access size / sign encodings carried in funct3
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // FSM states
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Byte-enable patterns
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    // Byte enables for an access of the given size at the given byte offset.
    // Size lives in funct3[1:0]; the sign bit does not affect lanes.
    function automatic logic [3:0] be_pattern(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = BE_BYTE0 << off;
            2'b01:   be = off[1] ? BE_HALF_HI : BE_HALF_LO;
            default: be = BE_WORD;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/load_store_unit_load_formatter.sv
// Load formatter: picks the addressed lane from a bus word and sign/zero extends it.
// Latency: combinational.
// Backpressure: none.
module load_formatter
    import load_store_unit_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [31:0] w_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane select then extension according to the access type
    always_comb begin
        w_shift = i_word >> {i_off, 3'b000};
        w_byte  = w_shift[7:0];
        w_half  = i_off[1] ? i_word[31:16] : i_word[15:0];
        case (i_funct3)
            F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            F3_LH:   o_data = {{16{w_half[15]}}, w_half};
            F3_LBU:  o_data = {24'd0, w_byte};
            F3_LHU:  o_data = {16'd0, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: aligns core loads/stores onto a req/ack data bus and formats load results.
// Latency: 2 + REQ cycles before ack (3 minimum); aborted after TIMEOUT_CYCLES REQ cycles.
// Backpressure: holds stall high from issue until the bus acks or times out.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        fault,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] C_MAX  = CW'(TIMEOUT_CYCLES);

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_bus_err;
    logic [31:0]   r_rdata;
    logic [2:0]    r_f3;
    logic [1:0]    r_off;
    logic          r_we;
    logic [31:0]   r_addr;
    logic [3:0]    r_be;
    logic [31:0]   r_wdata;

    logic          w_access;
    logic          w_f3_ok;
    logic          w_aligned;
    logic          w_start;
    logic [31:0]   w_fmt;

    // Legality and alignment of the access presented in IDLE
    always_comb begin
        w_access = mem_read | mem_write;
        if (mem_write)
            w_f3_ok = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW);
        else
            w_f3_ok = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
                      (funct3 == F3_LBU) || (funct3 == F3_LHU);
        case (funct3[1:0])
            2'b01:   w_aligned = ~addr[0];
            2'b10:   w_aligned = (addr[1:0] == 2'b00);
            default: w_aligned = 1'b1;
        endcase
        w_start = (r_state == S_IDLE) && w_access && w_f3_ok && w_aligned;
        fault   = (r_state == S_IDLE) && w_access && !(w_f3_ok && w_aligned);
        stall   = w_start || (r_state == S_REQ);
    end

    // FSM, timeout counter and load-data capture; a timeout forces the captured word to zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bus_err <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_bus_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_REQ;
                        r_cnt   <= '0;
                    end
                end
                S_REQ: begin
                    if (r_cnt != C_MAX)
                        r_cnt <= r_cnt + 1'b1;
                    // An ack in the final allowed cycle still wins over the timeout
                    if (bus_ack) begin
                        r_rdata <= bus_rdata;
                        r_state <= S_DONE;
                    end else if (r_cnt == C_LAST) begin
                        r_rdata   <= '0;
                        r_bus_err <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Bus request fields latched at issue so they stay stable for the whole REQ phase
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_be    <= '0;
            r_wdata <= '0;
            r_f3    <= '0;
            r_off   <= '0;
        end else if (w_start) begin
            r_we   <= mem_write;
            r_addr <= {addr[31:2], 2'b00};
            r_be   <= be_pattern(funct3, addr[1:0]);
            r_f3   <= funct3;
            r_off  <= addr[1:0];
            case (funct3[1:0])
                2'b00:   r_wdata <= {4{store_data[7:0]}};
                2'b01:   r_wdata <= {2{store_data[15:0]}};
                default: r_wdata <= store_data;
            endcase
        end
    end

    load_formatter u_fmt (
        .i_word   (r_rdata),
        .i_off    (r_off),
        .i_funct3 (r_f3),
        .o_data   (w_fmt)
    );

    assign read_data = (r_state == S_DONE) ? w_fmt : 32'd0;
    assign bus_req   = (r_state == S_REQ);
    assign bus_err   = r_bus_err;
    assign bus_we    = r_we;
    assign bus_addr  = r_addr;
    assign bus_be    = r_be;
    assign bus_wdata = r_wdata;

endmodule
